uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin frame arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters. Each requester offers bytes with a valid/ready handshake and marks its final byte with a last flag. The arbiter grants one requester per frame, feeds its bytes one at a time into the transmitter's data-valid/byte inputs, and paces on the transmitter's done pulse. It sits between the acquisition/command sources and the single serial TX port.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: grant index width; must be ≥ clog2(`NUM_REQ`).
- `STALL_MAX`, 255: max idle cycles inside a frame before abort; 8-bit counter.

- `i_Clock`  in  1  system clock.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Req_Valid`  in  NUM_REQ  per-requester byte valid.
- `i_Req_Byte`  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- `i_Req_Last`  in  NUM_REQ  per-requester last-byte-of-frame flag, qualified by valid.
- `o_Req_Ready`  out  NUM_REQ  one-cycle accept pulse; at most one bit high.
- `o_Grant_Valid`  out  1  high while a frame is owned.
- `o_Grant_Id`  out  ID_W  index of current owner; valid when `o_Grant_Valid`.
- `o_Tx_DV`  out  1  one-cycle start pulse to transmitter.
- `o_Tx_Byte`  out  8  byte to transmitter; stable from the `o_Tx_DV` cycle until `i_Tx_Done`.
- `i_Tx_Active`  in  1  transmitter busy.
- `i_Tx_Done`  in  1  transmitter one-cycle completion pulse.
- `o_Abort`  out  1  one-cycle pulse when a frame is aborted by stall timeout.

## Operation
- States: IDLE, TAG (macro only), FETCH, SEND, WAIT, GAP.
- IDLE: if any `i_Req_Valid` is high and `i_Tx_Active`=0, pick the first valid index searching upward (with wrap) from `ptr`. Latch it into `o_Grant_Id`, set `o_Grant_Valid`, and go to TAG or FETCH. Otherwise stay.
- FETCH: if `i_Req_Valid[id]`, pulse `o_Req_Ready[id]`, capture the byte into `o_Tx_Byte` and last into `r_last`, clear the stall counter, and go to SEND. Otherwise increment the stall counter. On reaching `STALL_MAX`, pulse `o_Abort`, release the grant, advance `ptr`, and go to IDLE.
- SEND: `o_Tx_DV`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `i_Tx_Done`=1, then go to GAP.
- GAP: one mandatory cycle, because the transmitter needs one cleanup cycle after done and ignores DV during it. If `r_last`, release the grant, set `ptr`=id+1 mod `NUM_REQ`, and go to IDLE. Otherwise go to FETCH.
- Fairness: a frame is never preempted. After a frame ends, the just-served requester has lowest priority.
- Other requesters' valid/last inputs are ignored while a frame is in progress. Their ready stays 0.

## Timing
- Reset (async assert, sync release): state IDLE, `ptr`=0, all outputs 0, `o_Tx_Byte`=0x00.
- Latency, IDLE with valid to `o_Tx_DV`: 3 cycles (IDLE→FETCH→SEND); 4 with the tag.
- Intra-frame spacing: next `o_Tx_DV` comes 3 cycles after `i_Tx_Done` (GAP, FETCH, SEND) when data is ready.
- Minimum `o_Tx_DV` spacing: never within 2 cycles after `i_Tx_Done`.
- Valid and last sampled in the same cycle: a single-byte frame is legal.
- `i_Tx_Done` outside WAIT is ignored.
- Reset mid-frame: the grant drops immediately and no further DV is issued. The transmitter completes its in-flight byte independently; IDLE waits for `i_Tx_Active`=0.

## Configuration
- `UART_ARB_TAG_EN` defined: on grant, TAG loads `o_Tx_Byte` = 0xA0 | id and then sequences SEND→WAIT→GAP→FETCH. Every frame is therefore prefixed by one header byte identifying its source. Abort during the payload is unchanged.
- Undefined: no TAG state; the frame carries payload bytes only.

## Test plan
- Single requester 0 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33) → three `o_Tx_DV` pulses carrying those bytes, three `o_Req_Ready[0]` pulses, and the grant drops in the GAP after the third done.
- Requesters 1 and 2 both hold valid single-byte frames continuously → grant order 1, 2, 1, 2.
- Requester 3 mid-frame with requester 0 valid → no preemption; requester 0 is granted only after requester 3's last byte.
- Requester 0 offers byte 0x55 without last, then drops valid → `o_Abort` pulses after 255 stall cycles and requester 1 is then granted.
- A transmitter model that drops DV during its cleanup cycle → zero lost bytes over 64 back-to-back bytes. Check that `o_Tx_DV` never occurs at `i_Tx_Done`+1.
- With `UART_ARB_TAG_EN`, requester 2 sends 0x7E with last → serial bytes 0xA2, 0x7E. Async reset asserted during WAIT clears every output within the same cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one UART transmitter
// Optional feature macro: UART_ARB_TAG_EN (prefix each frame with header byte 0xA0 | id)
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int STALL_MAX = 255
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic                 o_Grant_Valid,
  output logic [ID_W-1:0]      o_Grant_Id,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Abort
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
`ifdef UART_ARB_TAG_EN
    ,
    S_TAG   = 3'd5
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ID_W-1:0]   r_ptr;
  logic              r_grant_valid;
  logic [ID_W-1:0]   r_grant_id;
  logic [7:0]        r_tx_byte;
  logic              r_last;
  logic [7:0]        r_stall;

  logic              w_pick_found;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_sel_valid;
  logic [7:0]        w_sel_byte;
  logic              w_sel_last;
  logic              w_accept;
  logic              w_stall_hit;
  logic [ID_W-1:0]   w_next_ptr;

  assign o_Grant_Valid = r_grant_valid;
  assign o_Grant_Id    = r_grant_id;
  assign o_Tx_Byte     = r_tx_byte;

  // The counter would reach STALL_MAX with this idle cycle, so abort now.
  assign w_stall_hit = (r_stall == 8'(STALL_MAX - 1));

  // Owner after the current one gets first look at the next frame.
  assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_pick_found && i_Req_Valid[j] && (j == ((int'(r_ptr) + i) % NUM_REQ))) begin
          w_pick_found = 1'b1;
          w_pick_id    = ID_W'(j);
        end
      end
    end
  end

  // Route the granted requester's valid/byte/last; everyone else is ignored.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_byte  = '0;
    w_sel_last  = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r_grant_id == ID_W'(j)) begin
        w_sel_valid = i_Req_Valid[j];
        w_sel_byte  = i_Req_Byte[8*j +: 8];
        w_sel_last  = i_Req_Last[j];
      end
    end
  end

  // Accept pulse goes only to the owner, only in the cycle its byte is taken.
  always_comb begin
    o_Req_Ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_accept && (r_grant_id == ID_W'(j))) begin
        o_Req_Ready[j] = 1'b1;
      end
    end
  end

  // State register; reset drops the frame at once, in-flight serial byte finishes on its own.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and pulse outputs.
  always_comb begin
    w_next_state = r_state;
    o_Tx_DV      = 1'b0;
    o_Abort      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found && !i_Tx_Active) begin
`ifdef UART_ARB_TAG_EN
          w_next_state = S_TAG;
`else
          w_next_state = S_FETCH;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        w_next_state = S_SEND;
      end
`endif
      S_FETCH: begin
        if (w_sel_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_SEND;
        end else if (w_stall_hit) begin
          o_Abort      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_SEND: begin
        o_Tx_DV      = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        // Transmitter ignores DV in its cleanup cycle, so always spend one here.
        w_next_state = r_last ? S_IDLE : S_FETCH;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Grant, pointer, byte holding register and stall counter.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_ptr         <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_tx_byte     <= 8'h00;
      r_last        <= 1'b0;
      r_stall       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next_state != S_IDLE) begin
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_pick_id;
            r_stall       <= 8'd0;
          end
        end
`ifdef UART_ARB_TAG_EN
        S_TAG: begin
          r_tx_byte <= 8'hA0 | {4'h0, 4'(r_grant_id)};
          r_last    <= 1'b0;
        end
`endif
        S_FETCH: begin
          if (w_accept) begin
            r_tx_byte <= w_sel_byte;
            r_last    <= w_sel_last;
            r_stall   <= 8'd0;
          end else if (w_stall_hit) begin
            r_grant_valid <= 1'b0;
            r_ptr         <= w_next_ptr;
            r_stall       <= 8'd0;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end
        S_GAP: begin
          if (r_last) begin
            r_grant_valid <= 1'b0;
            r_ptr         <= w_next_ptr;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
